ctrl_pipe: RTL and testbench
============================

# ctrl_pipe

Carries decoded control bundles (`ctrl_signals_t` from `riscv_pkg`) from the decode stage through the EX, MEM and WB pipeline registers of the 5-stage core. It consumes what the decoder produces and keeps the pipeline correct while doing so:
- detects load-use hazards and stalls IF/ID;
- squashes wrong-path instructions on a taken branch or jump;
- freezes the whole pipeline while data memory is busy;
- generates operand-forwarding selects for the EX stage.

## Interface
Parameters:
- `REG_W`, default 5: register-index width.

Ports (clock and reset first):
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_valid` in 1: the ID stage holds a real instruction.
- `id_ctrl` in 17: decoded `ctrl_signals_t`.
- `id_rs1`, `id_rs2`, `id_rd` in `REG_W` each: register indices of the ID instruction.
- `ex_redirect` in 1: the instruction in EX is a taken branch/jump. Computed in EX from `ex_ctrl`.
- `mem_wait` in 1: data memory is not ready.
- `ex_valid`, `mem_valid`, `wb_valid` out 1: stage occupancy.
- `ex_ctrl`, `mem_ctrl`, `wb_ctrl` out 17: stage control bundles.
- `ex_rd`, `mem_rd`, `wb_rd` out `REG_W`: destination register of each stage.
- `ex_rs1`, `ex_rs2` out `REG_W`: source indices in EX.
- `fwd_a`, `fwd_b` out 2: EX operand select. 00 = register file, 01 = MEM-stage result, 10 = WB-stage result.
- `stall` out 1: hold PC and the IF/ID register.
- `flush` out 1: kill the IF/ID register contents.
- `wb_we` out 1: register-file write enable.

## Operation
Stage registers:
- EX, MEM and WB registers hold {valid, ctrl, rd}; EX also holds rs1 and rs2.
- A bubble is valid=0, ctrl=all-zero (alu_op=ALU_ADD, all enables 0), rd=0.

Hazard terms:
- `load_use` = `ex_valid` & `ex_ctrl.mem_read` & (`ex_rd`≠0) & `id_valid` & (`ex_rd`==`id_rs1` | `ex_rd`==`id_rs2`).
- The comparison is conservative: both sources are always compared.

Next-state priority, evaluated every cycle:
1. `mem_wait`=1: every stage register holds its value. `stall`=1, `flush`=0, `wb_we`=0. `ex_redirect` is ignored; because EX is frozen, it re-presents next cycle.
2. `ex_redirect`=1: EX←bubble, MEM←EX, WB←MEM. `flush`=1, `stall`=0. A concurrent `load_use` is ignored.
3. `load_use`=1: EX←bubble, MEM←EX, WB←MEM. `stall`=1, `flush`=0.
4. Otherwise: EX←ID (valid=`id_valid`; an invalid ID yields a bubble), MEM←EX, WB←MEM.

Forwarding, per EX source. `fwd_a` uses `ex_rs1`; `fwd_b` uses `ex_rs2`:
- 01 if `mem_valid` & `mem_ctrl.reg_write` & `mem_rd`≠0 & `mem_rd`==src.
- else 10 if `wb_valid` & `wb_ctrl.reg_write` & `wb_rd`≠0 & `wb_rd`==src.
- else 00.
- MEM has priority over WB (it holds the younger result).
- Forwarding is computed even when `ex_valid`=0; consumers ignore it.

Other outputs:
- `wb_we` = `wb_valid` & `wb_ctrl.reg_write` & (`wb_rd`≠0) & !`mem_wait`.
- x0 is never forwarded, never triggers a stall and is never written.

## Timing
- Reset (asynchronous, while `rst_n`=0):
  - all valids 0;
  - all ctrl, rd and rs fields 0;
  - `fwd_a`=`fwd_b`=00;
  - `stall`=`flush`=`wb_we`=0.
- Stage registers are registered outputs. `stall`, `flush`, `fwd_*` and `wb_we` are combinational from the registers and inputs, with no input-to-register-to-output bubble.
- Latency from ID acceptance:
  - EX: edge +1;
  - MEM: edge +2;
  - WB: edge +3 (`wb_we` asserted during that cycle).
- Load-use costs exactly one bubble. On the following cycle the load sits in MEM, so the dependent instruction enters EX with the load in WB and `fwd`=10.
- Redirect kills exactly the ID instruction, via the bubble into EX. The IF instruction is killed by the fetch unit on `flush`.
- Reset asserted mid-stream clears all stages immediately. The first instruction after `rst_n` rises enters EX on the first edge where `id_valid`=1.

## Test plan
- Reset mid-stream: three valid instructions in flight, drive `rst_n`=0 → same cycle, all valids 0, `stall`=0, `flush`=0, `fwd`=00.
- `add x5,x1,x2` then `sub x6,x5,x3` → while `sub` is in EX, `fwd_a`=01. Insert one NOP between them instead → `fwd_a`=10.
- `lw x6,0(x1)` then `add x7,x6,x1` → `stall`=1 for exactly one cycle and `ex_valid`=0 the next cycle. When `add` reaches EX, `fwd_a`=10.
- Taken `beq` in EX (`ex_redirect`=1) with `id_valid`=1, also matching `load_use` → `flush`=1, `stall`=0, next `ex_valid`=0. The branch advances to MEM.
- `mem_wait`=1 for 3 cycles with an `addi x4` in WB → all stage outputs unchanged, `stall`=1, `wb_we`=0. On the cycle `mem_wait` drops, `wb_we`=1 exactly once.
- `lw x0,0(x1)` followed by `add x2,x0,x0` → no stall, `fwd_a`=`fwd_b`=00, `wb_we`=0 for the load.

Source files
------------

// File: rtl/ctrl_pipe_if.sv
// ctrl_pipe_if: bundle between the decode stage, the EX/MEM/WB control
// pipeline and its consumers. The ctrl field is the 17-bit decoded control
// bundle; an all-zero bundle means alu_op=ADD with every enable cleared.
// The master side is the core (decode/EX/memory).
// The slave side is the control pipeline itself.
interface ctrl_pipe_if #(
    parameter int REG_W  = 5,
    parameter int CTRL_W = 17
);
    // Decode-stage inputs and pipeline control inputs
    logic              id_valid;
    logic [CTRL_W-1:0] id_ctrl;
    logic [REG_W-1:0]  id_rs1;
    logic [REG_W-1:0]  id_rs2;
    logic [REG_W-1:0]  id_rd;
    logic              ex_redirect;
    logic              mem_wait;

    // Stage contents
    logic              ex_valid;
    logic              mem_valid;
    logic              wb_valid;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [CTRL_W-1:0] mem_ctrl;
    logic [CTRL_W-1:0] wb_ctrl;
    logic [REG_W-1:0]  ex_rd;
    logic [REG_W-1:0]  mem_rd;
    logic [REG_W-1:0]  wb_rd;
    logic [REG_W-1:0]  ex_rs1;
    logic [REG_W-1:0]  ex_rs2;

    // Hazard / forwarding outputs
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              stall;
    logic              flush;
    logic              wb_we;

    modport master (
        output id_valid, id_ctrl, id_rs1, id_rs2, id_rd, ex_redirect, mem_wait,
        input  ex_valid, mem_valid, wb_valid, ex_ctrl, mem_ctrl, wb_ctrl,
        input  ex_rd, mem_rd, wb_rd, ex_rs1, ex_rs2,
        input  fwd_a, fwd_b, stall, flush, wb_we
    );

    modport slave (
        input  id_valid, id_ctrl, id_rs1, id_rs2, id_rd, ex_redirect, mem_wait,
        output ex_valid, mem_valid, wb_valid, ex_ctrl, mem_ctrl, wb_ctrl,
        output ex_rd, mem_rd, wb_rd, ex_rs1, ex_rs2,
        output fwd_a, fwd_b, stall, flush, wb_we
    );
endinterface

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: EX/MEM/WB control pipeline registers for the 5-stage core.
// Handles load-use stalls, redirect squashing, memory-wait freezing and
// EX operand-forwarding selects. Stage registers are the outputs; stall,
// flush, fwd_* and wb_we are combinational from registers and inputs.
// Bit positions of reg_write and mem_read inside the control bundle are
// parameters so the layout of the decoder's bundle can be matched.
module ctrl_pipe #(
    parameter int REG_W          = 5,
    parameter int CTRL_W         = 17,
    parameter int CTRL_REG_WRITE = 0,
    parameter int CTRL_MEM_READ  = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    ctrl_pipe_if.slave   bus
);

    // Stage registers
    logic              r_ex_valid,  r_mem_valid,  r_wb_valid;
    logic [CTRL_W-1:0] r_ex_ctrl,   r_mem_ctrl,   r_wb_ctrl;
    logic [REG_W-1:0]  r_ex_rd,     r_mem_rd,     r_wb_rd;
    logic [REG_W-1:0]  r_ex_rs1,    r_ex_rs2;

    // Next-state values
    logic              ex_valid_next,  mem_valid_next,  wb_valid_next;
    logic [CTRL_W-1:0] ex_ctrl_next,   mem_ctrl_next,   wb_ctrl_next;
    logic [REG_W-1:0]  ex_rd_next,     mem_rd_next,     wb_rd_next;
    logic [REG_W-1:0]  ex_rs1_next,    ex_rs2_next;

    // Hazard and forwarding terms
    logic              w_load_use;
    logic              w_ex_bubble;
    logic              w_mem_writes;
    logic              w_wb_writes;
    logic [REG_W-1:0]  w_src [2];
    logic [1:0]        w_fwd [2];

    // A load in EX whose destination matches either ID source; both
    // sources are compared even if the ID instruction does not use one.
    assign w_load_use = r_ex_valid && r_ex_ctrl[CTRL_MEM_READ] && (r_ex_rd != '0)
                     && bus.id_valid
                     && ((r_ex_rd == bus.id_rs1) || (r_ex_rd == bus.id_rs2));

    // EX receives a bubble on redirect, on load-use, or when ID is empty.
    assign w_ex_bubble = bus.ex_redirect || w_load_use || !bus.id_valid;

    // Stages that will write a non-x0 register.
    assign w_mem_writes = r_mem_valid && r_mem_ctrl[CTRL_REG_WRITE] && (r_mem_rd != '0);
    assign w_wb_writes  = r_wb_valid  && r_wb_ctrl[CTRL_REG_WRITE]  && (r_wb_rd  != '0);

    assign w_src[0] = r_ex_rs1;
    assign w_src[1] = r_ex_rs2;

    // Per-source forwarding: MEM holds the younger result, so it wins over WB.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            assign w_fwd[gi] = (w_mem_writes && (r_mem_rd == w_src[gi])) ? 2'b01 :
                               (w_wb_writes  && (r_wb_rd  == w_src[gi])) ? 2'b10 :
                                                                           2'b00;
        end
    endgenerate

    // Next-state selection: freeze on mem_wait, otherwise shift with EX fed
    // either by the ID instruction or by a bubble.
    always_comb begin
        ex_valid_next  = r_ex_valid;
        ex_ctrl_next   = r_ex_ctrl;
        ex_rd_next     = r_ex_rd;
        ex_rs1_next    = r_ex_rs1;
        ex_rs2_next    = r_ex_rs2;
        mem_valid_next = r_mem_valid;
        mem_ctrl_next  = r_mem_ctrl;
        mem_rd_next    = r_mem_rd;
        wb_valid_next  = r_wb_valid;
        wb_ctrl_next   = r_wb_ctrl;
        wb_rd_next     = r_wb_rd;

        if (!bus.mem_wait) begin
            wb_valid_next  = r_mem_valid;
            wb_ctrl_next   = r_mem_ctrl;
            wb_rd_next     = r_mem_rd;
            mem_valid_next = r_ex_valid;
            mem_ctrl_next  = r_ex_ctrl;
            mem_rd_next    = r_ex_rd;
            if (w_ex_bubble) begin
                ex_valid_next = 1'b0;
                ex_ctrl_next  = '0;
                ex_rd_next    = '0;
                ex_rs1_next   = '0;
                ex_rs2_next   = '0;
            end else begin
                ex_valid_next = 1'b1;
                ex_ctrl_next  = bus.id_ctrl;
                ex_rd_next    = bus.id_rd;
                ex_rs1_next   = bus.id_rs1;
                ex_rs2_next   = bus.id_rs2;
            end
        end
    end

    // Stage register update; reset empties every stage immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid  <= 1'b0;
            r_ex_ctrl   <= '0;
            r_ex_rd     <= '0;
            r_ex_rs1    <= '0;
            r_ex_rs2    <= '0;
            r_mem_valid <= 1'b0;
            r_mem_ctrl  <= '0;
            r_mem_rd    <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_ctrl   <= '0;
            r_wb_rd     <= '0;
        end else begin
            r_ex_valid  <= ex_valid_next;
            r_ex_ctrl   <= ex_ctrl_next;
            r_ex_rd     <= ex_rd_next;
            r_ex_rs1    <= ex_rs1_next;
            r_ex_rs2    <= ex_rs2_next;
            r_mem_valid <= mem_valid_next;
            r_mem_ctrl  <= mem_ctrl_next;
            r_mem_rd    <= mem_rd_next;
            r_wb_valid  <= wb_valid_next;
            r_wb_ctrl   <= wb_ctrl_next;
            r_wb_rd     <= wb_rd_next;
        end
    end

    assign bus.ex_valid  = r_ex_valid;
    assign bus.mem_valid = r_mem_valid;
    assign bus.wb_valid  = r_wb_valid;
    assign bus.ex_ctrl   = r_ex_ctrl;
    assign bus.mem_ctrl  = r_mem_ctrl;
    assign bus.wb_ctrl   = r_wb_ctrl;
    assign bus.ex_rd     = r_ex_rd;
    assign bus.mem_rd    = r_mem_rd;
    assign bus.wb_rd     = r_wb_rd;
    assign bus.ex_rs1    = r_ex_rs1;
    assign bus.ex_rs2    = r_ex_rs2;
    assign bus.fwd_a     = w_fwd[0];
    assign bus.fwd_b     = w_fwd[1];

    // Control outputs are held inactive while reset is asserted, whatever
    // the inputs are doing. A redirect during mem_wait is deferred.
    assign bus.stall = rst_n && (bus.mem_wait || (!bus.ex_redirect && w_load_use));
    assign bus.flush = rst_n && !bus.mem_wait && bus.ex_redirect;
    assign bus.wb_we = rst_n && w_wb_writes && !bus.mem_wait;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed table of cycles, a mid-stream reset sequence and
// random stimulus, all compared against a slot-array model of the pipeline.
module tb_ctrl_pipe;

    localparam int RW_B = 0;
    localparam int MR_B = 1;
    localparam logic [16:0] C_ADD = 17'h00001;
    localparam logic [16:0] C_SUB = 17'h00009;
    localparam logic [16:0] C_LW  = 17'h00103;
    localparam logic [16:0] C_BRL = 17'h00046;   // taken-branch bundle with mem_read set, to force load-use
    localparam logic [16:0] C_NOP = 17'h00000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ctrl_pipe_if #(.REG_W(5), .CTRL_W(17)) bus ();

    ctrl_pipe #(.REG_W(5), .CTRL_W(17), .CTRL_REG_WRITE(0), .CTRL_MEM_READ(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Model: slot 0 = EX, 1 = MEM, 2 = WB
    typedef struct {
        bit        v;
        bit [16:0] c;
        bit [4:0]  rd;
        bit [4:0]  rs1;
        bit [4:0]  rs2;
    } slot_t;
    slot_t m [3];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        bit        iv;
        bit [16:0] c;
        bit [4:0]  rd, rs1, rs2;
        bit        redir, mw;
        bit        e_stall, e_flush, e_exv;
        bit [1:0]  e_fa, e_fb;
        bit        e_we;
    } vec_t;
    vec_t tbl [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit [1:0] ref_fwd(input bit [4:0] src);
        if (src == 5'd0) return 2'b00;
        for (int s = 1; s < 3; s++)
            if (m[s].v && m[s].c[RW_B] && (m[s].rd == src))
                return (s == 1) ? 2'b01 : 2'b10;
        return 2'b00;
    endfunction

    function automatic bit ref_lu();
        return m[0].v && m[0].c[MR_B] && (m[0].rd != 0) && (bus.id_valid === 1'b1)
            && ((m[0].rd == bus.id_rs1) || (m[0].rd == bus.id_rs2));
    endfunction

    task automatic drive(input bit iv, input bit [16:0] c, input bit [4:0] rd,
                         input bit [4:0] rs1, input bit [4:0] rs2,
                         input bit redir, input bit mw);
        bus.id_valid    = iv;
        bus.id_ctrl     = c;
        bus.id_rd       = rd;
        bus.id_rs1      = rs1;
        bus.id_rs2      = rs2;
        bus.ex_redirect = redir;
        bus.mem_wait    = mw;
    endtask

    // Compare every DUT output against the model (reset-aware).
    task automatic check_all();
        bit mw, rd, run;
        mw  = bus.mem_wait;
        rd  = bus.ex_redirect;
        run = rst_n;
        chk("ex_valid",  bus.ex_valid,  m[0].v);
        chk("mem_valid", bus.mem_valid, m[1].v);
        chk("wb_valid",  bus.wb_valid,  m[2].v);
        chk("ex_ctrl",   bus.ex_ctrl,   m[0].c);
        chk("mem_ctrl",  bus.mem_ctrl,  m[1].c);
        chk("wb_ctrl",   bus.wb_ctrl,   m[2].c);
        chk("ex_rd",     bus.ex_rd,     m[0].rd);
        chk("mem_rd",    bus.mem_rd,    m[1].rd);
        chk("wb_rd",     bus.wb_rd,     m[2].rd);
        chk("ex_rs1",    bus.ex_rs1,    m[0].rs1);
        chk("ex_rs2",    bus.ex_rs2,    m[0].rs2);
        chk("fwd_a",     bus.fwd_a,     ref_fwd(m[0].rs1));
        chk("fwd_b",     bus.fwd_b,     ref_fwd(m[0].rs2));
        chk("stall",     bus.stall,     run && (mw || (!rd && ref_lu())));
        chk("flush",     bus.flush,     run && !mw && rd);
        chk("wb_we",     bus.wb_we,     run && m[2].v && m[2].c[RW_B] && (m[2].rd != 0) && !mw);
    endtask

    // Advance one clock, updating the model by the stage-shift rules.
    task automatic advance();
        slot_t n [3];
        n = m;
        if (!bus.mem_wait) begin
            n[2] = m[1];
            n[1] = m[0];
            if (bus.ex_redirect || ref_lu() || !bus.id_valid)
                n[0] = '{default: 0};
            else
                n[0] = '{1'b1, bus.id_ctrl, bus.id_rd, bus.id_rs1, bus.id_rs2};
        end
        @(posedge clk);
        m = n;
        @(negedge clk);
        cyc++;
    endtask

    function automatic vec_t vec(input bit iv, input bit [16:0] c, input bit [4:0] rd,
                                 input bit [4:0] rs1, input bit [4:0] rs2,
                                 input bit redir, input bit mw,
                                 input bit e_stall, input bit e_flush, input bit e_exv,
                                 input bit [1:0] e_fa, input bit [1:0] e_fb, input bit e_we);
        vec_t t;
        t = '{iv, c, rd, rs1, rs2, redir, mw, e_stall, e_flush, e_exv, e_fa, e_fb, e_we};
        return t;
    endfunction

    initial begin
        //            iv  ctrl   rd  rs1 rs2 rdr mw  stl flu exv fa     fb     we
        // add x5,x1,x2 ; sub x6,x5,x3 (MEM forward)
        tbl.push_back(vec(1, C_ADD,  5, 1, 2, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0));
        tbl.push_back(vec(1, C_SUB,  6, 5, 3, 0, 0,  0, 0, 1, 2'b00, 2'b00, 0));
        tbl.push_back(vec(0, C_NOP,  0, 0, 0, 0, 0,  0, 0, 1, 2'b01, 2'b00, 0));
        tbl.push_back(vec(0, C_NOP,  0, 0, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00, 1));
        tbl.push_back(vec(0, C_NOP,  0, 0, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00, 1));
        tbl.push_back(vec(0, C_NOP,  0, 0, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0));
        // add ; nop ; sub (WB forward)
        tbl.push_back(vec(1, C_ADD,  5, 1, 2, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0));
        tbl.push_back(vec(1, C_NOP,  0, 0, 0, 0, 0,  0, 0, 1, 2'b00, 2'b00, 0));
        tbl.push_back(vec(1, C_SUB,  6, 5, 3, 0, 0,  0, 0, 1, 2'b00, 2'b00, 0));
        tbl.push_back(vec(0, C_NOP,  0, 0, 0, 0, 0,  0, 0, 1, 2'b10, 2'b00, 1));
        tbl.push_back(vec(0, C_NOP,  0, 0, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0));
        tbl.push_back(vec(0, C_NOP,  0, 0, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00, 1));
        tbl.push_back(vec(0, C_NOP,  0, 0, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0));
        // lw x6,0(x1) ; add x7,x6,x1 (one bubble, then WB forward)
        tbl.push_back(vec(1, C_LW,   6, 1, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0));
        tbl.push_back(vec(1, C_ADD,  7, 6, 1, 0, 0,  1, 0, 1, 2'b00, 2'b00, 0));
        tbl.push_back(vec(1, C_ADD,  7, 6, 1, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0));
        tbl.push_back(vec(0, C_NOP,  0, 0, 0, 0, 0,  0, 0, 1, 2'b10, 2'b00, 1));
        tbl.push_back(vec(0, C_NOP,  0, 0, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0));
        tbl.push_back(vec(0, C_NOP,  0, 0, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00, 1));
        tbl.push_back(vec(0, C_NOP,  0, 0, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0));
        // redirect in EX together with a load-use match
        tbl.push_back(vec(1, C_BRL,  9, 1, 2, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0));
        tbl.push_back(vec(1, C_ADD, 10, 9, 0, 1, 0,  0, 1, 1, 2'b00, 2'b00, 0));
        tbl.push_back(vec(0, C_NOP,  0, 0, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0));
        tbl.push_back(vec(0, C_NOP,  0, 0, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0));
        tbl.push_back(vec(0, C_NOP,  0, 0, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0));
        // addi x4 held in WB for three mem_wait cycles
        tbl.push_back(vec(1, C_ADD,  4, 1, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0));
        tbl.push_back(vec(0, C_NOP,  0, 0, 0, 0, 0,  0, 0, 1, 2'b00, 2'b00, 0));
        tbl.push_back(vec(0, C_NOP,  0, 0, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0));
        tbl.push_back(vec(0, C_NOP,  0, 0, 0, 0, 1,  1, 0, 0, 2'b00, 2'b00, 0));
        tbl.push_back(vec(0, C_NOP,  0, 0, 0, 0, 1,  1, 0, 0, 2'b00, 2'b00, 0));
        tbl.push_back(vec(0, C_NOP,  0, 0, 0, 0, 1,  1, 0, 0, 2'b00, 2'b00, 0));
        tbl.push_back(vec(0, C_NOP,  0, 0, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00, 1));
        tbl.push_back(vec(0, C_NOP,  0, 0, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0));
        // lw x0 ; add x2,x0,x0 (x0 never stalls, forwards or writes)
        tbl.push_back(vec(1, C_LW,   0, 1, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0));
        tbl.push_back(vec(1, C_ADD,  2, 0, 0, 0, 0,  0, 0, 1, 2'b00, 2'b00, 0));
        tbl.push_back(vec(0, C_NOP,  0, 0, 0, 0, 0,  0, 0, 1, 2'b00, 2'b00, 0));
        tbl.push_back(vec(0, C_NOP,  0, 0, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0));
        tbl.push_back(vec(0, C_NOP,  0, 0, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00, 1));
        tbl.push_back(vec(0, C_NOP,  0, 0, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00, 0));

        // Initial reset
        for (int s = 0; s < 3; s++) m[s] = '{default: 0};
        rst_n = 1'b0;
        drive(0, C_NOP, 0, 0, 0, 0, 0);
        #1;
        check_all();
        $display("reset: ex_valid=%b stall=%b flush=%b wb_we=%b", bus.ex_valid, bus.stall, bus.flush, bus.wb_we);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].iv, tbl[i].c, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].redir, tbl[i].mw);
            #1;
            check_all();
            chk("tbl_stall",    bus.stall,    tbl[i].e_stall);
            chk("tbl_flush",    bus.flush,    tbl[i].e_flush);
            chk("tbl_ex_valid", bus.ex_valid, tbl[i].e_exv);
            chk("tbl_fwd_a",    bus.fwd_a,    tbl[i].e_fa);
            chk("tbl_fwd_b",    bus.fwd_b,    tbl[i].e_fb);
            chk("tbl_wb_we",    bus.wb_we,    tbl[i].e_we);
            $display("vec %0d: stall=%b flush=%b ex_valid=%b fwd=%b/%b wb_we=%b",
                     i, bus.stall, bus.flush, bus.ex_valid, bus.fwd_a, bus.fwd_b, bus.wb_we);
            advance();
        end

        // Mid-stream reset with three instructions in flight
        for (int i = 1; i <= 3; i++) begin
            drive(1, C_ADD, 5'(i), 5'(i + 1), 5'(i + 2), 0, 0);
            #1;
            check_all();
            $display("fill %0d: ex_valid=%b mem_valid=%b wb_valid=%b", i, bus.ex_valid, bus.mem_valid, bus.wb_valid);
            advance();
        end
        drive(0, C_NOP, 0, 0, 0, 0, 0);
        #1;
        chk("inflight_wb_valid", bus.wb_valid, 1'b1);
        rst_n = 1'b0;
        for (int s = 0; s < 3; s++) m[s] = '{default: 0};
        #1;
        check_all();
        chk("midrst_ex_valid", bus.ex_valid, 1'b0);
        chk("midrst_wb_valid", bus.wb_valid, 1'b0);
        $display("mid reset: ex/mem/wb valid=%b%b%b stall=%b flush=%b fwd=%b/%b",
                 bus.ex_valid, bus.mem_valid, bus.wb_valid, bus.stall, bus.flush, bus.fwd_a, bus.fwd_b);
        @(negedge clk);
        drive(1, C_ADD, 3, 1, 2, 0, 0);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, C_NOP, 0, 0, 0, 0, 0);

        // Random stimulus against the model
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 4) != 0, 17'($urandom), 5'($urandom % 4), 5'($urandom % 4),
                  5'($urandom % 4), ($urandom % 7) == 0, ($urandom % 6) == 0);
            #1;
            check_all();
            $display("rnd %0d: id_valid=%b redir=%b mw=%b stall=%b flush=%b fwd=%b/%b wb_we=%b",
                     i, bus.id_valid, bus.ex_redirect, bus.mem_wait, bus.stall, bus.flush,
                     bus.fwd_a, bus.fwd_b, bus.wb_we);
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
